// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the five-stage pipeline and its stall/flush
// sequencer. The slave side is the sequencer; the master side is the pipeline.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [4:0]       exe_rd;
   logic             exe_wr_en;
   logic             exe_is_load;
   logic             exe_is_div;
   logic             exe_redirect;
   logic             mem_wait;
   logic             div_done;
   logic             pc_en;
   logic             ifid_stall;
   logic             idexe_stall;
   logic             exemem_stall;
   logic             memwb_stall;
   logic             ifid_flush;
   logic             idexe_flush;
   logic             exemem_flush;
   logic             memwb_flush;
   logic             div_start;
   logic             div_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redirect_cnt;

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, exe_rd, exe_wr_en,
             exe_is_load, exe_is_div, exe_redirect, mem_wait, div_done,
      output pc_en, ifid_stall, idexe_stall, exemem_stall, memwb_stall,
             ifid_flush, idexe_flush, exemem_flush, memwb_flush,
             div_start, div_timeout, stall_cnt, redirect_cnt
   );

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, exe_rd, exe_wr_en,
             exe_is_load, exe_is_div, exe_redirect, mem_wait, div_done,
      input  pc_en, ifid_stall, idexe_stall, exemem_stall, memwb_stall,
             ifid_flush, idexe_flush, exemem_flush, memwb_flush,
             div_start, div_timeout, stall_cnt, redirect_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline: load-use bubbles,
// divider start/done sequencing with timeout, redirect flushes and data-memory
// wait states, plus stall and redirect performance counters.
module pipeline_hazard_ctrl #(
   parameter int DIV_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input logic                   clk,
   input logic                   nrst,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int              DC_W     = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
   localparam logic [DC_W-1:0] DIV_LAST = DC_W'(DIV_TIMEOUT - 1);

   typedef enum logic {RUN, DIV_BUSY} state_t;

   state_t           state, state_nxt;
   logic [DC_W-1:0]  div_cnt, div_cnt_nxt;
   logic             done_pend, done_pend_nxt;
   logic             timeout_set;
   logic             redirect_acc;
   logic             load_use;
   logic             div_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redirect_cnt;

   logic pc_en, div_start;
   logic ifid_stall, idexe_stall, exemem_stall, memwb_stall;
   logic ifid_flush, idexe_flush, exemem_flush, memwb_flush;

   assign load_use = hz.exe_is_load & hz.exe_wr_en & (hz.exe_rd != 5'd0) &
                     ((hz.id_use_rs1 & (hz.id_rs1 == hz.exe_rd)) |
                      (hz.id_use_rs2 & (hz.id_rs2 == hz.exe_rd)));

   // Next-state and control outputs, resolved in priority order:
   // reset, mem_wait, divider, redirect, load-use, none.
   always_comb begin
      state_nxt     = state;
      div_cnt_nxt   = div_cnt;
      done_pend_nxt = done_pend;
      timeout_set   = 1'b0;
      redirect_acc  = 1'b0;
      pc_en         = 1'b1;
      div_start     = 1'b0;
      ifid_stall    = 1'b0;
      idexe_stall   = 1'b0;
      exemem_stall  = 1'b0;
      memwb_stall   = 1'b0;
      ifid_flush    = 1'b0;
      idexe_flush   = 1'b0;
      exemem_flush  = 1'b0;
      memwb_flush   = 1'b0;

      if (!nrst) begin
         pc_en        = 1'b0;
         ifid_flush   = 1'b1;
         idexe_flush  = 1'b1;
         exemem_flush = 1'b1;
         memwb_flush  = 1'b1;
      end else if (hz.mem_wait) begin
         // Freeze everything up to EXE/MEM; WB drains into bubbles. Redirect
         // and load-use inputs persist because EXE is frozen.
         pc_en        = 1'b0;
         ifid_stall   = 1'b1;
         idexe_stall  = 1'b1;
         exemem_stall = 1'b1;
         memwb_flush  = 1'b1;
         if (state == DIV_BUSY) begin
            // The timeout clock keeps running; it saturates so the release
            // happens on the first cycle the wait lifts.
            if (div_cnt != DIV_LAST)
               div_cnt_nxt = div_cnt + DC_W'(1);
            if (hz.div_done)
               done_pend_nxt = 1'b1;
         end
      end else if (state == DIV_BUSY) begin
         if (hz.div_done | done_pend | (div_cnt == DIV_LAST)) begin
            // Release: all stalls drop so EXE/MEM captures the result.
            state_nxt     = RUN;
            done_pend_nxt = 1'b0;
            timeout_set   = ~(hz.div_done | done_pend);
         end else begin
            pc_en        = 1'b0;
            ifid_stall   = 1'b1;
            idexe_stall  = 1'b1;
            exemem_stall = 1'b1;
            memwb_flush  = 1'b1;
            div_cnt_nxt  = div_cnt + DC_W'(1);
         end
      end else if (hz.exe_is_div) begin
         div_start    = 1'b1;
         pc_en        = 1'b0;
         ifid_stall   = 1'b1;
         idexe_stall  = 1'b1;
         exemem_stall = 1'b1;
         state_nxt    = DIV_BUSY;
         div_cnt_nxt  = '0;
      end else if (hz.exe_redirect) begin
         // Redirect wins over load-use: the ID instruction is on the wrong path.
         ifid_flush   = 1'b1;
         idexe_flush  = 1'b1;
         redirect_acc = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         ifid_stall  = 1'b1;
         idexe_flush = 1'b1;
      end
   end

   // FSM state, divider cycle counter, pending-done and sticky timeout flag.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= RUN;
         div_cnt     <= '0;
         done_pend   <= 1'b0;
         div_timeout <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_cnt_nxt;
         done_pend <= done_pend_nxt;
         if (timeout_set)
            div_timeout <= 1'b1;
      end
   end

   // Performance counters, wrapping at their width.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         if (!pc_en)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (redirect_acc)
            redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
   end

   assign hz.pc_en        = pc_en;
   assign hz.div_start    = div_start;
   assign hz.ifid_stall   = ifid_stall;
   assign hz.idexe_stall  = idexe_stall;
   assign hz.exemem_stall = exemem_stall;
   assign hz.memwb_stall  = memwb_stall;
   assign hz.ifid_flush   = ifid_flush;
   assign hz.idexe_flush  = idexe_flush;
   assign hz.exemem_flush = exemem_flush;
   assign hz.memwb_flush  = memwb_flush;
   assign hz.div_timeout  = div_timeout;
   assign hz.stall_cnt    = stall_cnt;
   assign hz.redirect_cnt = redirect_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for single-cycle
// RUN-state decisions plus hand-written divider, wait-state and reset sequences.
module tb_pipeline_hazard_ctrl;
   localparam int DIV_TIMEOUT = 8;
   localparam int CNT_W       = 32;

   logic clk;
   logic nrst;
   int   n_tot;
   int   n_pass;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipeline_hazard_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .nrst (nrst),
      .hz   (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // exp = {pc_en, ifid/idexe/exemem/memwb stall, ifid/idexe/exemem/memwb flush}
   typedef struct {
      logic       mem_wait;
      logic       redirect;
      logic       is_load;
      logic       wr_en;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[12];

   localparam logic [8:0] O_IDLE  = 9'b1_0000_0000;
   localparam logic [8:0] O_LU    = 9'b0_1000_0100;
   localparam logic [8:0] O_REDIR = 9'b1_0000_1100;
   localparam logic [8:0] O_WAIT  = 9'b0_1110_0001;
   localparam logic [8:0] O_DIVL  = 9'b0_1110_0000;
   localparam logic [8:0] O_DIVB  = 9'b0_1110_0001;
   localparam logic [8:0] O_RST   = 9'b0_0000_1111;

   function automatic logic [8:0] outs();
      return {hz.pc_en, hz.ifid_stall, hz.idexe_stall, hz.exemem_stall, hz.memwb_stall,
              hz.ifid_flush, hz.idexe_flush, hz.exemem_flush, hz.memwb_flush};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic idle();
      hz.id_rs1       = 5'd0;
      hz.id_rs2       = 5'd0;
      hz.id_use_rs1   = 1'b0;
      hz.id_use_rs2   = 1'b0;
      hz.exe_rd       = 5'd0;
      hz.exe_wr_en    = 1'b0;
      hz.exe_is_load  = 1'b0;
      hz.exe_is_div   = 1'b0;
      hz.exe_redirect = 1'b0;
      hz.mem_wait     = 1'b0;
      hz.div_done     = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      idle();
      hz.mem_wait     = v.mem_wait;
      hz.exe_redirect = v.redirect;
      hz.exe_is_load  = v.is_load;
      hz.exe_wr_en    = v.wr_en;
      hz.exe_rd       = v.rd;
      hz.id_rs1       = v.rs1;
      hz.id_rs2       = v.rs2;
      hz.id_use_rs1   = v.use1;
      hz.id_use_rs2   = v.use2;
   endtask

   // Inputs change just after the rising edge; outputs are read on the falling edge.
   task automatic cyc_start();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      int busy;
      n_tot  = 0;
      n_pass = 0;

      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_IDLE};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, O_LU};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, O_IDLE};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, O_LU};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, O_IDLE};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, O_IDLE};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, O_IDLE};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_REDIR};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, O_REDIR};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_WAIT};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, O_WAIT};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, O_IDLE};

      // Reset state
      idle();
      nrst = 1'b0;
      #2;
      chk("rst_outs", 64'(outs()), 64'(O_RST));
      chk("rst_div_start", 64'(hz.div_start), 64'd0);
      chk("rst_stall_cnt", 64'(hz.stall_cnt), 64'd0);
      chk("rst_timeout", 64'(hz.div_timeout), 64'd0);
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      sample();
      chk("post_rst_idle", 64'(outs()), 64'(O_IDLE));

      // Single-cycle RUN-state decisions
      for (int i = 0; i < 12; i++) begin
         cyc_start();
         apply(tbl[i]);
         sample();
         chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
         chk($sformatf("vec%0d_div_start", i), 64'(hz.div_start), 64'd0);
      end
      cyc_start();
      idle();
      sample();
      chk("tbl_stall_cnt", 64'(hz.stall_cnt), 64'd4);
      chk("tbl_redirect_cnt", 64'(hz.redirect_cnt), 64'd2);

      // Divider: launch, six busy cycles, done on the seventh
      cyc_start();
      hz.exe_is_div = 1'b1;
      sample();
      chk("div_launch", 64'(outs()), 64'(O_DIVL));
      chk("div_launch_start", 64'(hz.div_start), 64'd1);
      for (int i = 0; i < 6; i++) begin
         cyc_start();
         sample();
         chk($sformatf("div_busy%0d", i), 64'(outs()), 64'(O_DIVB));
         chk($sformatf("div_busy%0d_start", i), 64'(hz.div_start), 64'd0);
      end
      cyc_start();
      hz.div_done = 1'b1;
      sample();
      chk("div_release", 64'(outs()), 64'(O_IDLE));
      chk("div_release_start", 64'(hz.div_start), 64'd0);

      // Back-to-back DIV released at the earliest cycle (t+1)
      cyc_start();
      hz.div_done = 1'b0;
      sample();
      chk("div2_start", 64'(hz.div_start), 64'd1);
      cyc_start();
      hz.div_done = 1'b1;
      sample();
      chk("div2_release", 64'(outs()), 64'(O_IDLE));
      cyc_start();
      idle();
      hz.div_done = 1'b1;
      sample();
      chk("done_in_run_ignored", 64'(outs()), 64'(O_IDLE));
      chk("div_stall_cnt", 64'(hz.stall_cnt), 64'd12);

      // Timeout: no done ever arrives
      cyc_start();
      idle();
      hz.exe_is_div = 1'b1;
      sample();
      chk("to_launch_start", 64'(hz.div_start), 64'd1);
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         cyc_start();
         sample();
         if (hz.pc_en == 1'b1) break;
         busy++;
      end
      chk("to_busy_cycles", 64'(busy), 64'(DIV_TIMEOUT - 1));
      cyc_start();
      hz.exe_is_div = 1'b0;
      sample();
      chk("to_flag_set", 64'(hz.div_timeout), 64'd1);
      chk("to_stall_cnt", 64'(hz.stall_cnt), 64'd20);

      // mem_wait for 3 cycles with a pending redirect, then the redirect fires
      for (int i = 0; i < 3; i++) begin
         cyc_start();
         hz.mem_wait     = 1'b1;
         hz.exe_redirect = 1'b1;
         sample();
         chk($sformatf("mw_redir%0d", i), 64'(outs()), 64'(O_WAIT));
      end
      cyc_start();
      hz.mem_wait = 1'b0;
      sample();
      chk("mw_redir_fire", 64'(outs()), 64'(O_REDIR));
      cyc_start();
      idle();
      sample();
      chk("mw_redirect_cnt", 64'(hz.redirect_cnt), 64'd3);
      chk("mw_stall_cnt", 64'(hz.stall_cnt), 64'd23);

      // div_done during mem_wait in DIV_BUSY is honoured after the wait
      cyc_start();
      hz.exe_is_div = 1'b1;
      sample();
      chk("dp_launch_start", 64'(hz.div_start), 64'd1);
      cyc_start();
      sample();
      chk("dp_busy", 64'(outs()), 64'(O_DIVB));
      cyc_start();
      hz.mem_wait = 1'b1;
      hz.div_done = 1'b1;
      sample();
      chk("dp_wait_done", 64'(outs()), 64'(O_WAIT));
      cyc_start();
      hz.div_done = 1'b0;
      sample();
      chk("dp_wait2", 64'(outs()), 64'(O_WAIT));
      cyc_start();
      hz.mem_wait = 1'b0;
      sample();
      chk("dp_release", 64'(outs()), 64'(O_IDLE));
      cyc_start();
      idle();
      sample();
      chk("dp_stall_cnt", 64'(hz.stall_cnt), 64'd27);
      chk("dp_timeout_sticky", 64'(hz.div_timeout), 64'd1);

      // Asynchronous reset in the middle of DIV_BUSY
      cyc_start();
      hz.exe_is_div = 1'b1;
      sample();
      cyc_start();
      sample();
      chk("ar_busy", 64'(outs()), 64'(O_DIVB));
      #2 nrst = 1'b0;
      #1;
      chk("ar_outs", 64'(outs()), 64'(O_RST));
      chk("ar_div_start", 64'(hz.div_start), 64'd0);
      chk("ar_stall_cnt", 64'(hz.stall_cnt), 64'd0);
      chk("ar_redirect_cnt", 64'(hz.redirect_cnt), 64'd0);
      chk("ar_timeout", 64'(hz.div_timeout), 64'd0);
      cyc_start();
      idle();
      nrst = 1'b1;
      sample();
      chk("ar_run_idle", 64'(outs()), 64'(O_IDLE));
      chk("ar_cnt_after", 64'(hz.stall_cnt), 64'd0);
      cyc_start();
      hz.exe_is_div = 1'b1;
      sample();
      chk("ar_run_launch", 64'(hz.div_start), 64'd1);
      cyc_start();
      idle();
      hz.exe_is_div = 1'b1;
      hz.div_done   = 1'b1;
      sample();
      cyc_start();
      idle();
      sample();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
